// File: rtl/vic_pkg.sv
// Shared definitions for the VICtor interrupt link: source count, vector width,
// vector-table base default and the CPU-side entry FSM state encoding.
package vic_pkg;

  localparam int          NUM_IRQ         = 31;
  localparam int          VEC_W           = 5;
  localparam logic [31:0] VT_BASE_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BND = 3'd1,
    VT_RD    = 3'd2,
    VT_WAIT  = 3'd3,
    SERVICE  = 3'd4,
    RET      = 3'd5
  } state_e;

endpackage

// File: rtl/irq_pending_latch.sv
// Holds the pending interrupt request and its vector number. A new request in
// the same cycle as a clear wins, so a request arriving at handler entry is kept.
module irq_pending_latch
  import vic_pkg::*;
#(
  parameter int VEC_W = vic_pkg::VEC_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_set,
  input  logic [VEC_W-1:0] i_set_vec,
  input  logic             i_clr,
  output logic             o_pend,
  output logic [VEC_W-1:0] o_vec
);

  logic             pend_q, pend_d;
  logic [VEC_W-1:0] vec_q,  vec_d;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    pend_d = pend_q;
    vec_d  = vec_q;
    if (i_set) begin
      pend_d = 1'b1;
      vec_d  = i_set_vec;
    end else if (i_clr) begin
      pend_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= 1'b0;
      vec_q  <= '0;
    end else begin
      pend_q <= pend_d;
      vec_q  <= vec_d;
    end
  end

  assign o_pend = pend_q;
  assign o_vec  = vec_q;

endmodule

// File: rtl/irq_entry_ctrl.sv
// CPU-side interrupt entry/exit controller: latches the VIC request, saves the
// return PC at an instruction boundary, fetches the handler vector and redirects fetch.
module irq_entry_ctrl
  import vic_pkg::*;
#(
  parameter int             PC_W    = 32,
  parameter int             VEC_W   = vic_pkg::VEC_W,
  parameter logic [PC_W-1:0] VT_BASE = PC_W'(vic_pkg::VT_BASE_DEFAULT),
  parameter int             CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_irq,
  input  logic [VEC_W-1:0] i_irq_addr,
  input  logic             i_gie,
  input  logic             i_boundary,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_reti,
  input  logic [PC_W-1:0]  i_vt_data,
  output logic             o_vt_rd,
  output logic [PC_W-1:0]  o_vt_addr,
  output logic             o_redirect,
  output logic [PC_W-1:0]  o_target_pc,
  output logic [PC_W-1:0]  o_epc,
  output logic             o_in_service,
  output logic [CNT_W-1:0] o_irq_count,
  output logic             o_bad_reti
);

  state_e           state_q, state_d;
  logic             vt_rd_q, vt_rd_d;
  logic [PC_W-1:0]  vt_addr_q, vt_addr_d;
  logic             redirect_q, redirect_d;
  logic [PC_W-1:0]  target_pc_q, target_pc_d;
  logic [PC_W-1:0]  epc_q, epc_d;
  logic             in_service_q, in_service_d;
  logic [CNT_W-1:0] irq_count_q, irq_count_d;
  logic             bad_reti_q, bad_reti_d;

  logic             pend;
  logic [VEC_W-1:0] vec;
  logic             pend_clr;

  irq_pending_latch #(
    .VEC_W (VEC_W)
  ) u_pending (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_set     (i_irq),
    .i_set_vec (i_irq_addr),
    .i_clr     (pend_clr),
    .o_pend    (pend),
    .o_vec     (vec)
  );

  always_comb begin
    state_d      = state_q;
    vt_rd_d      = vt_rd_q;
    vt_addr_d    = vt_addr_q;
    redirect_d   = redirect_q;
    target_pc_d  = target_pc_q;
    epc_d        = epc_q;
    in_service_d = in_service_q;
    irq_count_d  = irq_count_q;
    bad_reti_d   = bad_reti_q;
    pend_clr     = 1'b0;

    // RETI is only meaningful while a handler runs; anywhere else it is flagged and dropped.
    if (i_reti && (state_q != SERVICE)) begin
      bad_reti_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pend && i_gie) state_d = WAIT_BND;
      end
      WAIT_BND: begin
        if (!i_gie) begin
          state_d = IDLE;
        end else if (i_boundary) begin
          epc_d     = i_pc;
          vt_addr_d = VT_BASE + PC_W'({vec, 2'b00});
          vt_rd_d   = 1'b1;
          state_d   = VT_RD;
        end
      end
      VT_RD: begin
        vt_rd_d = 1'b0;
        state_d = VT_WAIT;
      end
      VT_WAIT: begin
        target_pc_d  = i_vt_data;
        redirect_d   = 1'b1;
        in_service_d = 1'b1;
        pend_clr     = 1'b1;
        irq_count_d  = irq_count_q + CNT_W'(1);
        state_d      = SERVICE;
      end
      SERVICE: begin
        redirect_d = 1'b0;
        if (i_reti) begin
          target_pc_d  = epc_q;
          redirect_d   = 1'b1;
          in_service_d = 1'b0;
          state_d      = RET;
        end
      end
      RET: begin
        redirect_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      vt_rd_q      <= 1'b0;
      vt_addr_q    <= '0;
      redirect_q   <= 1'b0;
      target_pc_q  <= '0;
      epc_q        <= '0;
      in_service_q <= 1'b0;
      irq_count_q  <= '0;
      bad_reti_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vt_rd_q      <= vt_rd_d;
      vt_addr_q    <= vt_addr_d;
      redirect_q   <= redirect_d;
      target_pc_q  <= target_pc_d;
      epc_q        <= epc_d;
      in_service_q <= in_service_d;
      irq_count_q  <= irq_count_d;
      bad_reti_q   <= bad_reti_d;
    end
  end

  assign o_vt_rd      = vt_rd_q;
  assign o_vt_addr    = vt_addr_q;
  assign o_redirect   = redirect_q;
  assign o_target_pc  = target_pc_q;
  assign o_epc        = epc_q;
  assign o_in_service = in_service_q;
  assign o_irq_count  = irq_count_q;
  assign o_bad_reti   = bad_reti_q;

endmodule

// File: tb/tb_irq_entry_ctrl.sv
// Scoreboard bench for irq_entry_ctrl: stimulus queues expected vector reads and
// redirects; a negedge monitor pops and compares them as the DUT emits them.
module tb_irq_entry_ctrl;
  import vic_pkg::*;

  localparam int PC_W  = 32;
  localparam int VEC_W = vic_pkg::VEC_W;
  localparam int CNT_W = 2;

  logic             i_clk, i_rst_n, i_irq, i_gie, i_boundary, i_reti;
  logic [VEC_W-1:0] i_irq_addr;
  logic [PC_W-1:0]  i_pc, i_vt_data;
  logic             o_vt_rd, o_redirect, o_in_service, o_bad_reti;
  logic [PC_W-1:0]  o_vt_addr, o_target_pc, o_epc;
  logic [CNT_W-1:0] o_irq_count;

  irq_entry_ctrl #(
    .PC_W    (PC_W),
    .VEC_W   (VEC_W),
    .VT_BASE (32'h0),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_irq        (i_irq),
    .i_irq_addr   (i_irq_addr),
    .i_gie        (i_gie),
    .i_boundary   (i_boundary),
    .i_pc         (i_pc),
    .i_reti       (i_reti),
    .i_vt_data    (i_vt_data),
    .o_vt_rd      (o_vt_rd),
    .o_vt_addr    (o_vt_addr),
    .o_redirect   (o_redirect),
    .o_target_pc  (o_target_pc),
    .o_epc        (o_epc),
    .o_in_service (o_in_service),
    .o_irq_count  (o_irq_count),
    .o_bad_reti   (o_bad_reti)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] epc;
    int          cyc;
  } vt_exp_t;

  typedef struct {
    logic [31:0]      target;
    logic             in_svc;
    logic [CNT_W-1:0] cnt;
    int               cyc;
  } rd_exp_t;

  vt_exp_t vt_q[$];
  rd_exp_t rd_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_entries = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Handler table: entry 5 holds 0x2000, the rest are distinct per vector.
  function automatic logic [31:0] handler(input int n);
    return (n == 5) ? 32'h2000 : 32'h4000 + 32'(n) * 32'd16;
  endfunction

  // Vector-table memory with one cycle of read latency.
  always @(posedge i_clk) begin
    if (o_vt_rd) i_vt_data <= handler(int'(o_vt_addr >> 2));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected output pulse at cycle %0d", name, cyc);
  endtask

  // Monitor: every read strobe and redirect must match the next queued expectation.
  always @(negedge i_clk) begin
    if (o_vt_rd) begin
      if (vt_q.size() == 0) flag("vt_rd");
      else begin
        vt_exp_t e;
        e = vt_q.pop_front();
        check("vt_addr", o_vt_addr, e.addr);
        check("vt_epc", o_epc, e.epc);
        check("vt_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (o_redirect) begin
      if (rd_q.size() == 0) flag("redirect");
      else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check("rd_target", o_target_pc, e.target);
        check("rd_in_service", 32'(o_in_service), 32'(e.in_svc));
        check("rd_count", 32'(o_irq_count), 32'(e.cnt));
        check("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic pulse_irq(input int v);
    i_irq      = 1'b1;
    i_irq_addr = VEC_W'(v);
    tick(1);
    i_irq      = 1'b0;
  endtask

  // Call with the DUT in WAIT_BND; returns with it in SERVICE.
  task automatic enter(input int v, input logic [31:0] pc, input bit irq_in_wait, input int v2);
    n_entries++;
    i_boundary = 1'b1;
    i_pc       = pc;
    vt_q.push_back('{32'(v) * 32'd4, pc, cyc + 1});
    rd_q.push_back('{handler(v), 1'b1, CNT_W'(n_entries), cyc + 3});
    tick(1);
    i_boundary = 1'b0;
    i_pc       = '0;
    tick(1);
    if (irq_in_wait) begin
      i_irq      = 1'b1;
      i_irq_addr = VEC_W'(v2);
    end
    tick(1);
    i_irq = 1'b0;
    tick(1);
  endtask

  // Call in SERVICE; returns with the DUT back in IDLE.
  task automatic leave(input logic [31:0] pc);
    i_reti = 1'b1;
    rd_q.push_back('{pc, 1'b0, CNT_W'(n_entries), cyc + 1});
    tick(1);
    i_reti = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_irq = 1'b0; i_irq_addr = '0; i_gie = 1'b0;
    i_boundary = 1'b0; i_pc = '0; i_reti = 1'b0;
    #2;
    check("rst_vt_rd", 32'(o_vt_rd), 0);
    check("rst_redirect", 32'(o_redirect), 0);
    check("rst_in_service", 32'(o_in_service), 0);
    check("rst_count", 32'(o_irq_count), 0);
    check("rst_bad_reti", 32'(o_bad_reti), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick(2);

    // Basic entry and return.
    i_gie = 1'b1;
    pulse_irq(5);
    tick(1);
    enter(5, 32'h100, 1'b0, 0);
    check("basic_vt_addr", o_vt_addr, 32'h14);
    check("basic_epc", o_epc, 32'h100);
    check("basic_in_service", 32'(o_in_service), 1);
    check("basic_count", 32'(o_irq_count), 1);
    leave(32'h100);
    check("ret_in_service", 32'(o_in_service), 0);
    check("ret_target", o_target_pc, 32'h100);
    check("ret_redirect_low", 32'(o_redirect), 0);

    // Gating by i_gie: nothing may happen for 10 cycles.
    i_gie = 1'b0;
    pulse_irq(3);
    tick(10);
    i_gie = 1'b1;
    tick(1);
    enter(3, 32'h200, 1'b0, 0);
    leave(32'h200);

    // Overwrite while pending, stalled boundary, request during SERVICE.
    pulse_irq(7);
    pulse_irq(2);
    tick(2);
    enter(2, 32'h300, 1'b0, 0);
    pulse_irq(9);
    leave(32'h300);
    tick(1);
    enter(9, 32'h304, 1'b0, 0);
    check("wrap_count", 32'(o_irq_count), 0);
    leave(32'h304);

    // Request arriving in the entry cycle survives the pending clear.
    pulse_irq(11);
    tick(1);
    enter(11, 32'h400, 1'b1, 12);
    leave(32'h400);
    tick(1);
    enter(12, 32'h404, 1'b0, 0);
    leave(32'h404);

    // Spurious RETI in IDLE.
    check("bad_reti_before", 32'(o_bad_reti), 0);
    i_reti = 1'b1;
    tick(1);
    i_reti = 1'b0;
    check("bad_reti_set", 32'(o_bad_reti), 1);
    tick(5);
    check("bad_reti_sticky", 32'(o_bad_reti), 1);

    // Asynchronous reset while in VT_WAIT aborts the entry.
    pulse_irq(1);
    tick(1);
    i_boundary = 1'b1;
    i_pc       = 32'h500;
    vt_q.push_back('{32'h4, 32'h500, cyc + 1});
    tick(1);
    i_boundary = 1'b0;
    tick(1);
    i_rst_n = 1'b0;
    n_entries = 0;
    #1;
    check("arst_vt_rd", 32'(o_vt_rd), 0);
    check("arst_redirect", 32'(o_redirect), 0);
    check("arst_in_service", 32'(o_in_service), 0);
    check("arst_epc", o_epc, 0);
    check("arst_vt_addr", o_vt_addr, 0);
    check("arst_target", o_target_pc, 0);
    check("arst_count", 32'(o_irq_count), 0);
    check("arst_bad_reti", 32'(o_bad_reti), 0);
    tick(2);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick(10);
    check("post_rst_in_service", 32'(o_in_service), 0);
    check("post_rst_count", 32'(o_irq_count), 0);

    check("vt_queue_drained", 32'(vt_q.size()), 0);
    check("rd_queue_drained", 32'(rd_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
